// File: rtl/fnd_scan_controller.sv
// N-digit multiplexed common-anode 7-segment scan controller with frame snapshot,
// leading-zero blanking, per-digit blink and 8-level brightness PWM.
module fnd_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      blank_lead,
  input  logic [2:0]                brightness,
  output logic [NUM_DIGITS-1:0]     fnd_com,
  output logic [7:0]                fnd_data,
  output logic                      frame_start
);

  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int PH    = DIV / 8;
  localparam int PH_W  = (PH > 1) ? $clog2(PH) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [PH_W-1:0]         ph_cnt;
  logic [2:0]              phase;
  logic [IDX_W-1:0]        idx;
  logic [BC_W-1:0]         blink_cnt;
  logic                    blink_off;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_blank;

  logic                    ph_wrap;
  logic                    phase_wrap;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   nz;
  logic [3:0]              cur_nib;
  logic                    lead_blank;
  logic [NUM_DIGITS-1:0]   com_next;
  logic [7:0]              data_next;
  logic                    fs_next;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign ph_wrap    = (ph_cnt == PH_LAST);
  assign phase_wrap = ph_wrap && (phase == 3'd7);
  assign frame_wrap = phase_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_cnt    <= '0;
      phase     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!enable) begin
      ph_cnt    <= '0;
      phase     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      ph_cnt <= ph_wrap ? '0 : ph_cnt + 1'b1;
      if (ph_wrap)
        phase <= phase + 3'd1;
      if (phase_wrap)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (frame_wrap) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Snapshot tracks inputs while idle so the first frame after enable is current.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
      snap_blank  <= 1'b0;
    end else if (!enable || frame_wrap) begin
      snap_digits <= digits;
      snap_dp     <= dp_mask;
      snap_blink  <= blink_mask;
      snap_blank  <= blank_lead;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    assign nz[g] = |snap_digits[4*g +: 4];
  end

  assign cur_nib    = snap_digits[{idx, 2'b00} +: 4];
  assign lead_blank = snap_blank && (idx != '0) && ((nz >> idx) == '0);

  always_comb begin
    com_next  = '1;
    data_next = 8'hFF;
    fs_next   = 1'b0;
    if (enable) begin
      fs_next = (idx == '0) && (phase == '0) && (ph_cnt == '0);
      if (phase <= brightness) begin
        com_next[idx] = 1'b0;
        if (!(blink_off && snap_blink[idx])) begin
          data_next    = lead_blank ? 8'hFF : seg_decode(cur_nib);
          data_next[7] = ~snap_dp[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com     <= '1;
      fnd_data    <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      fnd_com     <= com_next;
      fnd_data    <= data_next;
      frame_start <= fs_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomised and directed bench for fnd_scan_controller; reference model works
// from elapsed scan time since enable and per-frame input snapshots.
module tb_fnd_scan_controller;

  localparam int N     = 4;
  localparam int BF    = 2;
  localparam int SLOT  = 64;
  localparam int PHC   = 8;
  localparam int FRAME = SLOT * N;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        blank_lead;
  logic [2:0]  brightness;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        frame_start;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .NUM_DIGITS  (N),
    .CLK_FREQ    (64),
    .SCAN_HZ     (1),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .blank_lead (blank_lead),
    .brightness (brightness),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data),
    .frame_start(frame_start)
  );

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: m_next is elapsed scan time of the upcoming edge; o_* is what the outputs show.
  logic        m_on;
  int          m_next, m_ot;
  logic [15:0] m_dig, o_dig;
  logic [3:0]  m_dp, o_dp, m_bm, o_bm;
  logic        m_bl, o_bl;
  logic [2:0]  o_br;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_on <= 1'b0; m_next <= 0; m_ot <= 0;
      m_dig <= '0; m_dp <= '0; m_bm <= '0; m_bl <= 1'b0;
    end else if (!enable) begin
      m_on <= 1'b0; m_next <= 0;
      m_dig <= digits; m_dp <= dp_mask; m_bm <= blink_mask; m_bl <= blank_lead;
    end else begin
      m_on <= 1'b1; m_ot <= m_next;
      o_dig <= m_dig; o_dp <= m_dp; o_bm <= m_bm; o_bl <= m_bl; o_br <= brightness;
      m_next <= m_next + 1;
      if ((m_next + 1) % FRAME == 0) begin
        m_dig <= digits; m_dp <= dp_mask; m_bm <= blink_mask; m_bl <= blank_lead;
      end
    end
  end

  function automatic logic [12:0] expected();
    int idx, ph, frame;
    logic [3:0] com, nib;
    logic [7:0] data;
    logic fs;
    if (!m_on) return {4'hF, 8'hFF, 1'b0};
    idx   = (m_ot / SLOT) % N;
    ph    = (m_ot % SLOT) / PHC;
    frame = m_ot / FRAME;
    fs    = (m_ot % FRAME) == 0;
    if (ph > int'(o_br)) return {4'hF, 8'hFF, fs};
    com = 4'hF;
    com[idx] = 1'b0;
    if ((((frame / BF) % 2) == 1) && o_bm[idx]) begin
      data = 8'hFF;
    end else begin
      nib  = 4'((o_dig >> (4 * idx)) & 16'hF);
      data = seg_tab[nib];
      if (o_bl && idx > 0 && (o_dig >> (4 * idx)) == 16'h0) data = 8'hFF;
      if (o_dp[idx]) data[7] = 1'b0;
    end
    return {com, data, fs};
  endfunction

  task automatic restart(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm,
                         input logic bl, input logic [2:0] br);
    @(negedge clk);
    digits = d; dp_mask = dp; blink_mask = bm; blank_lead = bl; brightness = br;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({fnd_com, fnd_data, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state com=%b data=%h fs=%b expected 1111/ff/0", fnd_com, fnd_data, frame_start);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({fnd_com, fnd_data, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL disabled_idle com=%b data=%h fs=%b expected 1111/ff/0", fnd_com, fnd_data, frame_start);
    end
  endtask

  task automatic test_basic_scan();
    logic [12:0] e;
    logic [7:0] bs [4];
    int fs_cnt;
    bs = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    fs_cnt = 0;
    restart(16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL basic_scan t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
      if (frame_start) fs_cnt++;
      if (m_ot % SLOT == 32) begin
        vectors++;
        if (fnd_data !== bs[(m_ot / SLOT) % N]) begin
          miscompares++;
          $display("FAIL basic_digit t=%0d data=%h expected %h", m_ot, fnd_data, bs[(m_ot / SLOT) % N]);
        end
      end
    end
    vectors++;
    if (fs_cnt != 2) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d expected 2", fs_cnt);
    end
  endtask

  task automatic test_dimming();
    logic [12:0] e;
    int lit;
    restart(16'h1234, 4'h0, 4'h0, 1'b0, 3'd3);
    for (int b = 0; b < 2; b++) begin
      lit = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        e = expected(); vectors++;
        if ({fnd_com, fnd_data, frame_start} !== e) begin
          miscompares++;
          $display("FAIL dimming t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                   m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
        end
        if (fnd_com !== 4'hF) lit++;
      end
      vectors++;
      if (lit != ((b == 0) ? 128 : 32)) begin
        miscompares++;
        $display("FAIL dim_lit_count br=%0d got %0d expected %0d", brightness, lit, (b == 0) ? 128 : 32);
      end
      brightness = 3'd0;
    end
  endtask

  task automatic test_leading_zero();
    logic [12:0] e;
    logic [15:0] dv [3];
    logic        bv [3];
    logic [7:0]  ex [3][4];
    dv = '{16'h0070, 16'h0070, 16'h0000};
    bv = '{1'b1, 1'b0, 1'b1};
    ex = '{'{8'hC0, 8'hF8, 8'hFF, 8'hFF}, '{8'hC0, 8'hF8, 8'hC0, 8'hC0}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
    for (int k = 0; k < 3; k++) begin
      restart(dv[k], 4'h0, 4'h0, bv[k], 3'd7);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        e = expected(); vectors++;
        if ({fnd_com, fnd_data, frame_start} !== e) begin
          miscompares++;
          $display("FAIL lead_zero case=%0d t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                   k, m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
        end
        if (m_ot % SLOT == 32) begin
          vectors++;
          if (fnd_data !== ex[k][m_ot / SLOT]) begin
            miscompares++;
            $display("FAIL lead_digit case=%0d digit=%0d data=%h expected %h", k, m_ot / SLOT, fnd_data, ex[k][m_ot / SLOT]);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [12:0] e;
    logic [7:0] ex [8];
    ex = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h80, 8'hF8, 8'h82, 8'h92};
    restart(16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL snapshot t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
      if (m_ot % SLOT == 40) begin
        vectors++;
        if (fnd_data !== ex[m_ot / SLOT]) begin
          miscompares++;
          $display("FAIL snap_digit slot=%0d data=%h expected %h", m_ot / SLOT, fnd_data, ex[m_ot / SLOT]);
        end
      end
      if (m_ot == SLOT + 20) digits = 16'h5678;
    end
  endtask

  task automatic test_blink_dp();
    logic [12:0] e;
    logic [7:0] want;
    restart(16'h1234, 4'b0100, 4'b0001, 1'b0, 3'd7);
    for (int c = 0; c < 8 * FRAME; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL blink_dp t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
      if (m_ot % FRAME == 32 || m_ot % FRAME == 2 * SLOT + 32) begin
        if (m_ot % FRAME == 32) want = (((m_ot / FRAME) / 2) % 2 == 1) ? 8'hFF : 8'h99;
        else                    want = 8'h24;
        vectors++;
        if (fnd_data !== want) begin
          miscompares++;
          $display("FAIL blink_digit t=%0d data=%h expected %h", m_ot, fnd_data, want);
        end
      end
    end
  endtask

  task automatic test_enable_mid();
    logic [12:0] e;
    logic found;
    found = 1'b0;
    restart(16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL enable_pre t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
      if (m_ot == 2 * SLOT + 10) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL enable_wait timeout reaching digit 2 got t=%0d expected %0d", m_ot, 2 * SLOT + 10);
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fnd_com, fnd_data, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL enable_drop com=%b data=%h fs=%b expected 1111/ff/0", fnd_com, fnd_data, frame_start);
    end
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fnd_com, fnd_data, frame_start} !== {4'b1110, 8'h99, 1'b1}) begin
      miscompares++;
      $display("FAIL enable_rise com=%b data=%h fs=%b expected 1110/99/1", fnd_com, fnd_data, frame_start);
    end
    for (int c = 0; c < FRAME + 40; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL enable_post t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    restart(16'h9ABC, 4'h0, 4'h0, 1'b0, 3'd7);
    repeat (SLOT + 30) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({fnd_com, fnd_data, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset com=%b data=%h fs=%b expected 1111/ff/0", fnd_com, fnd_data, frame_start);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < FRAME + 20; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL reset_restart t=%0d com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 m_ot, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    restart(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      e = expected(); vectors++;
      if ({fnd_com, fnd_data, frame_start} !== e) begin
        miscompares++;
        $display("FAIL random c=%0d en=%b com=%b data=%h fs=%b expected com=%b data=%h fs=%b",
                 c, m_on, fnd_com, fnd_data, frame_start, e[12:9], e[8:1], e[0]);
      end
      if ($urandom_range(29, 0) == 0) digits = (16'($urandom) & 16'($urandom));
      if ($urandom_range(39, 0) == 0) brightness = 3'($urandom);
      if ($urandom_range(59, 0) == 0) begin
        dp_mask = 4'($urandom); blink_mask = 4'($urandom); blank_lead = 1'($urandom);
      end
      if ($urandom_range(499, 0) == 0) enable = ~enable;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; digits = '0; dp_mask = '0; blink_mask = '0;
    blank_lead = 1'b0; brightness = 3'd7;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_scan();
    test_dimming();
    test_leading_zero();
    test_snapshot();
    test_blink_dp();
    test_enable_mid();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Parametrised N-digit multiplexed 7-segment scan controller that generalises the 4-digit display driver. It takes packed hex/BCD nibbles plus per-digit decimal-point and blink masks, and drives common-anode FND digit selects and segment data. Added over the previous generation: frame-synchronous input snapshot (no tearing), optional leading-zero blanking, per-digit blinking and 8-level brightness PWM. Sits between the time/stopwatch datapath and the board FND pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
CLK_FREQ, 100_000_000, clk frequency in Hz
SCAN_HZ, 1000, digit slot rate in Hz; DIV = CLK_FREQ/SCAN_HZ clocks per slot; CLK_FREQ must be divisible by 8*SCAN_HZ
BLINK_FRAMES, 125, full frames per blink half-period (>=1)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
enable  input  1  1 = scan active; 0 = display dark, scan held at start
digits  input  4*NUM_DIGITS  digit nibbles; [3:0] = digit 0 (rightmost)
dp_mask  input  NUM_DIGITS  1 = light decimal point of digit i
blink_mask  input  NUM_DIGITS  1 = digit i blinks
blank_lead  input  1  1 = blank leading zeros
brightness  input  3  on-phases per slot minus 1 (7 = full)
fnd_com  output  NUM_DIGITS  digit select, active-low, one-hot-low
fnd_data  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}
frame_start  output  1  one-clock pulse when digit 0 slot begins

Behaviour:
- Counters: ph_cnt 0..DIV/8-1; phase 0..7 increments on ph_cnt wrap; idx 0..NUM_DIGITS-1 increments when phase wraps 7->0; idx wraps to 0 after NUM_DIGITS-1.
- Reset: counters 0, snapshot 0, blink_cnt 0, blink_off 0, fnd_com all 1, fnd_data 8'hFF, frame_start 0.
- enable=0: counters, blink_cnt, blink_off synchronously cleared; snapshot registers load digits/dp_mask/blink_mask/blank_lead every clock; next-clock outputs fnd_com all 1, fnd_data FF, frame_start 0.
- Snapshot: while enabled, snapshot reloads only on the edge where idx wraps to 0. Input changes mid-frame are invisible until the next frame.
- Outputs are registered: they reflect counter/snapshot state one clock after that state. frame_start = 1 for the clock following entry into idx=0, phase=0, ph_cnt=0, including the first slot after enable rises.
- Digit select: fnd_com[idx]=0 when phase <= brightness; otherwise all 1 and fnd_data=FF. Lit time per slot is (brightness+1)/8 of DIV.
- Segment decode, dp bit set: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E.
- Leading-zero blank: digit i (i>=1) is blank if blank_lead and snapshot nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked. Blank = segment bits a..g off (7'h7F); dp is still applied.
- Blink: blink_cnt counts completed frames. At value BLINK_FRAMES-1 with a frame wrap, it clears and blink_off toggles. When blink_off=1, digits with blink_mask bit set output FF (dp also off). The com select is still driven.
- DP: fnd_data[7] = ~(dp_mask[idx]) unless blink-off or the dimming off-phase applies.
- Priority, off-phase/disabled > blink-off > leading blank > decode; dp is combined last.
- Reset mid-slot: outputs go dark asynchronously; scan restarts at digit 0 after release.

Test Plan:
- Bench params: NUM_DIGITS=4, CLK_FREQ=64, SCAN_HZ=1, BLINK_FRAMES=2 (DIV=64, phase=8 clocks).
- Basic scan: digits=16'h1234, brightness=7, masks 0 -> fnd_com 1110/99, 1101/B0, 1011/A4, 0111/F9, 64 clocks each; frame_start pulses every 256 clocks.
- Dimming: brightness=3 -> per slot, com active low 32 clocks then 1111 with data FF 32 clocks; brightness=0 -> 8 clocks lit.
- Leading zero: digits=16'h0070, blank_lead=1 -> digits 3,2 data FF, digit1 F8, digit0 C0. With blank_lead=0, digits 3,2 show C0. With digits=0000, digit0 shows C0.
- Snapshot: change digits 1234->5678 during the digit-1 slot -> digits 2,3 of that frame still A4/F9; next frame shows 92,82,F8,80 in scan order 0..3 as 80,F8,82,92.
- Blink and dp: blink_mask=0001, dp_mask=0100 -> digit0 shows 99 for 2 frames, FF for 2 frames, repeating; digit2 always shows 24.
- Enable/reset mid-frame: drop enable at idx=2 -> next clock 1111/FF. Re-enable -> digit0 first with frame_start; async reset assertion -> immediate 1111/FF.
